// File: rtl/alu_fsm_if.sv
// ============================================================================
//  Module   : alu_fsm_if
//  Brief    : Operand/select/result bundle between a driver and alu_fsm.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface alu_fsm_if;
   logic [3:0] a;
   logic [3:0] b;
   logic       cin;
   logic [2:0] sel;
   logic [4:0] out;
   logic       cout;

   modport master (output a, output b, output cin, output sel,
                   input  out, input cout);
   modport slave  (input  a, input  b, input  cin, input  sel,
                   output out, output cout);
endinterface

`default_nettype wire

// File: rtl/alu_fsm.sv
// ============================================================================
//  Module   : alu_fsm
//  Brief    : 4-bit sequential ALU; LOAD captures operands, EXEC registers a
//             5-bit result and carry/borrow/shift-out flag.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_fsm (
   input  wire logic  clk,
   input  wire logic  reset,
   alu_fsm_if.slave   alu_s
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_EXEC = 2'd2
   } state_t;

   localparam logic [2:0] C_OP_ADD = 3'b000;
   localparam logic [2:0] C_OP_SUB = 3'b001;
   localparam logic [2:0] C_OP_AND = 3'b010;
   localparam logic [2:0] C_OP_OR  = 3'b011;
   localparam logic [2:0] C_OP_XOR = 3'b100;
   localparam logic [2:0] C_OP_NOT = 3'b101;
   localparam logic [2:0] C_OP_SHL = 3'b110;
   localparam logic [2:0] C_OP_SHR = 3'b111;

   state_t     state_q;
   logic [3:0] a_q;
   logic [3:0] b_q;
   logic       cin_q;
   logic [2:0] sel_q;
   logic [4:0] out_q;
   logic       cout_q;

   logic [4:0] sum_w;
   logic [4:0] diff_w;
   logic [4:0] out_d;
   logic       cout_d;

   // Result depends only on the captured copies, so inputs moving during EXEC have no effect.
   always_comb begin
      sum_w  = {1'b0, a_q} + {1'b0, b_q} + {4'b0000, cin_q};
      diff_w = {1'b0, a_q} - {1'b0, b_q} - {4'b0000, cin_q};
      out_d  = sum_w;
      cout_d = sum_w[4];
      case (sel_q)
         C_OP_ADD: begin out_d = sum_w;                   cout_d = sum_w[4];  end
         C_OP_SUB: begin out_d = diff_w;                  cout_d = diff_w[4]; end
         C_OP_AND: begin out_d = {1'b0, a_q & b_q};       cout_d = 1'b0;      end
         C_OP_OR:  begin out_d = {1'b0, a_q | b_q};       cout_d = 1'b0;      end
         C_OP_XOR: begin out_d = {1'b0, a_q ^ b_q};       cout_d = 1'b0;      end
         C_OP_NOT: begin out_d = {1'b0, ~a_q};            cout_d = 1'b0;      end
         C_OP_SHL: begin out_d = {a_q, cin_q};            cout_d = a_q[3];    end
         C_OP_SHR: begin out_d = {1'b0, cin_q, a_q[3:1]}; cout_d = a_q[0];    end
         default:  begin out_d = sum_w;                   cout_d = sum_w[4];  end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         a_q     <= 4'd0;
         b_q     <= 4'd0;
         cin_q   <= 1'b0;
         sel_q   <= 3'd0;
         out_q   <= 5'd0;
         cout_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: state_q <= S_LOAD;
            S_LOAD: begin
               a_q     <= alu_s.a;
               b_q     <= alu_s.b;
               cin_q   <= alu_s.cin;
               sel_q   <= alu_s.sel;
               state_q <= S_EXEC;
            end
            S_EXEC: begin
               out_q   <= out_d;
               cout_q  <= cout_d;
               state_q <= S_LOAD;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign alu_s.out  = out_q;
   assign alu_s.cout = cout_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_fsm.sv
// ============================================================================
//  Module   : tb_alu_fsm
//  Brief    : Directed testbench for alu_fsm with hand-computed results.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_fsm;

   logic clk;
   logic reset;
   int   checks_q;
   int   errors_q;
   logic [4:0] prev_out;
   logic       prev_cout;

   alu_fsm_if alu_m ();

   alu_fsm dut (
      .clk   (clk),
      .reset (reset),
      .alu_s (alu_m)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks_q++;
      if (obs !== exp) begin
         errors_q++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Entered just after a result edge (DUT in LOAD); leaves just after the next result edge.
   task automatic run_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                         input logic cin, input logic [2:0] sel,
                         input logic [4:0] exp_out, input logic exp_cout);
      @(negedge clk);
      alu_m.a = a; alu_m.b = b; alu_m.cin = cin; alu_m.sel = sel;
      @(posedge clk); #1;
      chk({tag, "_hold_out"}, {3'b0, alu_m.out}, {3'b0, prev_out});
      chk({tag, "_hold_cout"}, {7'b0, alu_m.cout}, {7'b0, prev_cout});
      @(posedge clk); #1;
      chk({tag, "_out"}, {3'b0, alu_m.out}, {3'b0, exp_out});
      chk({tag, "_cout"}, {7'b0, alu_m.cout}, {7'b0, exp_cout});
      prev_out  = exp_out;
      prev_cout = exp_cout;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      checks_q = 0; errors_q = 0;
      prev_out = 5'd0; prev_cout = 1'b0;
      alu_m.a = 4'd0; alu_m.b = 4'd0; alu_m.cin = 1'b0; alu_m.sel = 3'd0;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out", {3'b0, alu_m.out}, 8'd0);
      chk("rst_cout", {7'b0, alu_m.cout}, 8'd0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk); #1;
      chk("idle_out", {3'b0, alu_m.out}, 8'd0);

      run_op("add", 4'd5, 4'd12, 1'b0, 3'b000, 5'd17, 1'b1);
      run_op("sub", 4'd5, 4'd12, 1'b0, 3'b001, 5'd25, 1'b1);
      run_op("and", 4'd5, 4'd12, 1'b0, 3'b010, 5'd4,  1'b0);
      run_op("or",  4'd5, 4'd12, 1'b0, 3'b011, 5'd13, 1'b0);
      run_op("xor", 4'd5, 4'd12, 1'b0, 3'b100, 5'd9,  1'b0);
      run_op("not", 4'd5, 4'd12, 1'b0, 3'b101, 5'd10, 1'b0);
      run_op("shl", 4'd5, 4'd12, 1'b0, 3'b110, 5'd10, 1'b0);
      run_op("shr", 4'd5, 4'd12, 1'b0, 3'b111, 5'd2,  1'b1);
      run_op("shl_cin", 4'd9, 4'd0, 1'b1, 3'b110, 5'd19, 1'b1);
      run_op("shr_cin", 4'd6, 4'd0, 1'b1, 3'b111, 5'd11, 1'b0);
      run_op("add_max", 4'd15, 4'd15, 1'b1, 3'b000, 5'd31, 1'b1);
      run_op("sub_eq",  4'd7,  4'd7,  1'b0, 3'b001, 5'd0,  1'b0);
      run_op("sub_neg", 4'd0,  4'd0,  1'b1, 3'b001, 5'd31, 1'b1);
      run_op("sub_pos", 4'd9,  4'd3,  1'b1, 3'b001, 5'd5,  1'b0);

      // Inputs changed during EXEC must not affect the result.
      @(negedge clk);
      alu_m.a = 4'd3; alu_m.b = 4'd4; alu_m.cin = 1'b1; alu_m.sel = 3'b000;
      @(posedge clk); #1;
      alu_m.a = 4'd15; alu_m.b = 4'd1; alu_m.sel = 3'b011;
      @(posedge clk); #1;
      chk("exec_ign_out", {3'b0, alu_m.out}, 8'd8);
      chk("exec_ign_cout", {7'b0, alu_m.cout}, 8'd0);
      @(posedge clk); #1;
      chk("load_hold_out", {3'b0, alu_m.out}, 8'd8);
      @(posedge clk); #1;
      chk("next_or_out", {3'b0, alu_m.out}, 8'd15);
      prev_out = 5'd15; prev_cout = 1'b0;

      run_op("pre_rst", 4'd15, 4'd15, 1'b1, 3'b000, 5'd31, 1'b1);

      // Asynchronous reset in the middle of EXEC.
      @(negedge clk);
      alu_m.a = 4'd15; alu_m.b = 4'd15; alu_m.cin = 1'b0; alu_m.sel = 3'b000;
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      chk("arst_out", {3'b0, alu_m.out}, 8'd0);
      chk("arst_cout", {7'b0, alu_m.cout}, 8'd0);
      @(negedge clk);
      reset = 1'b0;
      alu_m.a = 4'd5; alu_m.b = 4'd12; alu_m.cin = 1'b0; alu_m.sel = 3'b000;
      @(posedge clk); #1;
      chk("arst_idle_out", {3'b0, alu_m.out}, 8'd0);
      prev_out = 5'd0; prev_cout = 1'b0;
      run_op("post_rst", 4'd5, 4'd12, 1'b0, 3'b000, 5'd17, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks_q, errors_q);
      $finish;
   end

endmodule

`default_nettype wire
